// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin arbiter serialising NUM_REQ Avalon-MM masters onto one downstream port.
// Optional downstream timeout abort enabled by defining SPI_BUS_ARBITER_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [ADDR_W-1:0]         avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [DATA_W-1:0]         avm_writedata,
  input  logic                      avm_waitrequest,
  input  logic [DATA_W-1:0]         avm_readdata,
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output logic [2:0]                grant_id,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;
  state_e              state_q;
  logic [2:0]          grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rd_q;
  logic                wr_q;
  logic [NUM_REQ-1:0]  wait_q;
  logic [7:0]          req_pad;
  logic [7:0]          wr_pad;
  logic [3:0]          idx;
  logic [2:0]          sel_d;
  logic                any_d;
  logic                to_d;
  assign req_pad = 8'(req_read | req_write);
  assign wr_pad  = 8'(req_write);
  // Scan downward so the first requester above the pointer wins.
  always_comb begin
    sel_d = grant_q;
    any_d = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = 4'(grant_q) + 4'(k);
      idx = (idx >= 4'(NUM_REQ)) ? idx - 4'(NUM_REQ) : idx;
      if (req_pad[idx[2:0]]) begin
        sel_d = idx[2:0];
        any_d = 1'b1;
      end
    end
  end
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  assign to_d        = avm_waitrequest && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == ISSUE) ? cnt_q + 1'b1 : '0;
      timeout_q <= timeout_q | ((state_q == ISSUE) & to_d);
    end
`else
  assign to_d = 1'b0;
`endif
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state_q <= IDLE;
      grant_q <= 3'(NUM_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wait_q  <= '1;
    end else begin
      case (state_q)
        IDLE: if (any_d) begin
          grant_q <= sel_d;
          addr_q  <= req_address[sel_d*ADDR_W +: ADDR_W];
          wdata_q <= req_writedata[sel_d*DATA_W +: DATA_W];
          wr_q    <= wr_pad[sel_d];
          rd_q    <= ~wr_pad[sel_d];
          state_q <= ISSUE;
        end
        ISSUE: if (!avm_waitrequest || to_d) begin
          rdata_q <= !rd_q ? rdata_q : to_d ? DATA_W'(32'hDEAD_BEEF) : avm_readdata;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          wait_q  <= ~(NUM_REQ'(1) << grant_q);
          state_q <= DONE;
        end
        DONE: begin
          wait_q  <= '1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign req_waitrequest = wait_q;
  assign req_readdata    = rdata_q;
  assign avm_address     = addr_q;
  assign avm_read        = rd_q;
  assign avm_write       = wr_q;
  assign avm_writedata   = wdata_q;
  assign grant_id        = grant_q;
  assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed self-checking bench for spi_bus_arbiter (NUM_REQ=2).
module tb_spi_bus_arbiter;
  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] req_address = '0;
  logic [1:0]  req_read = '0;
  logic [1:0]  req_write = '0;
  logic [63:0] req_writedata = '0;
  logic [1:0]  req_waitrequest;
  logic [31:0] req_readdata;
  logic [15:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b1;
  logic [31:0] avm_readdata = '0;
  logic [2:0]  grant_id;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
  logic        timeout_err;
`endif
  spi_bus_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
    .req_readdata(req_readdata), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .grant_id(grant_id), .busy(busy)
  );
  always #5 clk_clk = ~clk_clk;
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_wait", req_waitrequest, 2'b11);
    chk("rst_rdata", req_readdata, 0);
    chk("rst_avm", {avm_read, avm_write, avm_address, avm_writedata}, 0);
    chk("rst_grant", grant_id, 1);
    chk("rst_busy", busy, 0);
    reset_reset_n = 1'b1;
    // single read, zero wait
    req_read = 2'b01;
    req_address[15:0] = 16'h0010;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h1234_5678;
    tick();
    chk("rd_c1_read", avm_read, 1);
    chk("rd_c1_addr", avm_address, 16'h0010);
    chk("rd_c1_grant", grant_id, 0);
    chk("rd_c1_wait", req_waitrequest, 2'b11);
    tick();
    chk("rd_c2_read", avm_read, 0);
    chk("rd_c2_wait", req_waitrequest, 2'b10);
    chk("rd_c2_data", req_readdata, 32'h1234_5678);
    tick();
    req_read = 2'b00;
    chk("rd_c3_busy", busy, 0);
    chk("rd_c3_wait", req_waitrequest, 2'b11);
    // write with four downstream wait cycles
    avm_waitrequest = 1'b1;
    req_write = 2'b10;
    req_address[31:16] = 16'h0004;
    req_writedata[63:32] = 32'hA5A5_A5A5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("wr_strobe", {avm_write, avm_read}, 2'b10);
      chk("wr_addr", avm_address, 16'h0004);
      chk("wr_data", avm_writedata, 32'hA5A5_A5A5);
      chk("wr_stall", req_waitrequest, 2'b11);
      if (c == 5) avm_waitrequest = 1'b0;
    end
    tick();
    chk("wr_c6_wait", req_waitrequest, 2'b01);
    chk("wr_c6_write", avm_write, 0);
    chk("wr_c6_rdata", req_readdata, 32'h1234_5678);
    req_write = 2'b00;
    tick();
    chk("wr_c7_busy", busy, 0);
    // contention: both read continuously, expect 0,1,0,1
    req_read = 2'b11;
    req_address = {16'h0200, 16'h0100};
    for (int t = 0; t < 4; t++) begin
      avm_readdata = 32'hCAFE_0000 + t;
      tick();
      chk("ct_grant", grant_id, t % 2);
      chk("ct_read", avm_read, 1);
      chk("ct_addr", avm_address, (t % 2) ? 16'h0200 : 16'h0100);
      tick();
      chk("ct_wait", req_waitrequest, (t % 2) ? 2'b01 : 2'b10);
      chk("ct_data", req_readdata, 32'hCAFE_0000 + t);
      if (t == 3) req_read = 2'b00;
      tick();
    end
    chk("ct_idle", busy, 0);
    // simultaneous read and write is a write
    req_read = 2'b01;
    req_write = 2'b01;
    req_address[15:0] = 16'h0020;
    req_writedata[31:0] = 32'h1;
    tick();
    chk("rw_strobe", {avm_write, avm_read}, 2'b10);
    chk("rw_data", avm_writedata, 32'h1);
    chk("rw_grant", grant_id, 0);
    tick();
    chk("rw_wait", req_waitrequest, 2'b10);
    chk("rw_rdata", req_readdata, 32'hCAFE_0003);
    req_read = 2'b00;
    req_write = 2'b00;
    tick();
    // reset during ISSUE with a stalled slave
    avm_waitrequest = 1'b1;
    req_read = 2'b10;
    req_address[31:16] = 16'h0030;
    tick();
    chk("rs_read", avm_read, 1);
    chk("rs_grant", grant_id, 1);
    tick();
    #2 reset_reset_n = 1'b0;
    #1;
    chk("rs_async_read", avm_read, 0);
    chk("rs_async_busy", busy, 0);
    req_read = 2'b00;
    tick();
    reset_reset_n = 1'b1;
    tick();
    chk("rs_wait", req_waitrequest, 2'b11);
    chk("rs_grant_after", grant_id, 1);
    chk("rs_busy", busy, 0);
    chk("rs_rdata", req_readdata, 0);
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    chk("to_err_init", timeout_err, 0);
    req_read = 2'b01;
    req_address[15:0] = 16'h0040;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("to_read", avm_read, 1);
    end
    tick();
    chk("to_wait", req_waitrequest, 2'b10);
    chk("to_data", req_readdata, 32'hDEAD_BEEF);
    chk("to_err", timeout_err, 1);
    chk("to_read_off", avm_read, 0);
    req_read = 2'b00;
    tick();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Round-robin arbiter that lets NUM_REQ Avalon-MM masters share the single memory-mapped register space behind the SPI-chain slave bridge.
- Typical masters: the spislave bridge master, the id_switch/debug logic and future local sequencers.
- Serialises one transaction at a time onto one downstream Avalon-MM master port, and returns read data or an acknowledge to the winning requester.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- ADDR_W, 16, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT_CYCLES, 255, cycles before an unanswered downstream transaction is aborted (used only with the optional feature).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_read  in  NUM_REQ  per-requester read strobe.
- req_write  in  NUM_REQ  per-requester write strobe.
- req_writedata  in  NUM_REQ*DATA_W  per-requester write data.
- req_waitrequest  out  NUM_REQ  per-requester stall; 0 for exactly one cycle on completion.
- req_readdata  out  DATA_W  shared read data; valid while the granted requester's waitrequest is 0.
- avm_address  out  ADDR_W  downstream address.
- avm_read  out  1  downstream read.
- avm_write  out  1  downstream write.
- avm_writedata  out  DATA_W  downstream write data.
- avm_waitrequest  in  1  downstream stall.
- avm_readdata  in  DATA_W  downstream read data, sampled when avm_waitrequest=0.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: req_waitrequest = all ones; req_readdata = 0; all avm_* outputs = 0; grant_id = NUM_REQ-1; busy = 0; state = IDLE.
- Reset asynchronously clears all state, including mid-transaction. avm_read and avm_write drop immediately. No completion is signalled for an aborted transaction.
- Request: requester i is requesting when req_read[i] | req_write[i]. It must hold its command stable until it sees req_waitrequest[i]=0 (Avalon semantics).
- State IDLE:
  - If any request is pending, pick the first requesting index searching upward from grant_id+1 (mod NUM_REQ).
  - Register grant_id, address, writedata and the read/write command; go to ISSUE.
  - Read and write asserted together by the same requester is treated as a write.
  - No request pending: stay in IDLE.
- State ISSUE:
  - Drive the avm_* outputs from the registers; they stay constant for the whole state.
  - When avm_waitrequest=0: capture avm_readdata into req_readdata (reads only; writes leave req_readdata unchanged), deassert avm_read/avm_write at that edge, go to DONE.
- State DONE (exactly 1 cycle):
  - req_waitrequest[grant_id]=0; all other bits stay 1. Then go to IDLE.
  - The round-robin pointer is grant_id, updated only by a new grant.
- Latency:
  - Request first visible at cycle 0 leads to avm strobe from cycle 1.
  - With zero downstream wait, avm_waitrequest=0 in cycle 1 gives DONE in cycle 2, so the transaction completes in 3 cycles.
  - Each extra downstream wait cycle adds 1 cycle.
- Back-to-back: IDLE samples requests in the cycle after DONE. A requester that re-requests immediately is granted again only if no other index lies ahead of it in round-robin order.
- Fairness: a requester waits for at most NUM_REQ-1 other transactions.
- Requests withdrawn while waiting are illegal; the arbiter does not need to detect this. A withdrawn command after grant is still completed downstream.
- req_waitrequest for non-granted requesters is 1 at all times, including in IDLE.

Optional Feature:
- Macro: SPI_BUS_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When the counter reaches TIMEOUT_CYCLES with avm_waitrequest still 1, deassert avm_read/avm_write and go to DONE.
  - For reads, req_readdata = 32'hDEAD_BEEF (truncated or zero-extended to DATA_W).
  - A sticky output port timeout_err (1 bit, reset 0) is set and is cleared only by reset.
- When undefined: no counter, no timeout_err port, and ISSUE waits indefinitely.

Test Plan:
- Single read, zero wait:
  - Stimulus: requester 0 reads 0x0010; slave returns 0x12345678 with avm_waitrequest=0.
  - Response: avm_read high in cycle 1 only; req_waitrequest[0]=0 and req_readdata=0x12345678 in cycle 2; busy is 0 in cycle 3.
- Write with 4 downstream wait cycles:
  - Stimulus: requester 1 writes 0xA5A5A5A5 to 0x0004.
  - Response: avm_write, address and data are stable for 5 cycles; completion at cycle 6; req_readdata is unchanged.
- Contention:
  - Stimulus: both requesters read continuously after reset.
  - Response: grant order is 0,1,0,1; grant_id alternates; neither waits more than one transaction.
- Simultaneous read and write:
  - Stimulus: requester 0 asserts req_read and req_write together with writedata 0x1.
  - Response: only avm_write is issued.
- Reset mid-transaction:
  - Stimulus: assert reset_reset_n=0 during ISSUE with avm_waitrequest=1.
  - Response: avm_read=0 asynchronously; after release, state is IDLE, req_waitrequest all ones, grant_id=NUM_REQ-1.
- Timeout (SPI_BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: slave holds avm_waitrequest=1.
  - Response: completion after 8 ISSUE cycles with req_readdata=0xDEADBEEF and timeout_err=1.
